watch_time_decoder: RTL and testbench

WATCH_TIME_DECODER -- requirements
Module: watch_time_decoder

---
 rtl/watch_pkg.sv | 26 ++
 rtl/seg7_encoder.sv | 18 +
 rtl/watch_time_decoder.sv | 135 +++++++++++++
 tb/tb_watch_time_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch seconds decoder.
//   FINE_STATES / COARSE_STATES : number of positions of each watch code
//   COARSE_RESET / FINE_RESET   : code the watch presents out of reset
//   FINE_CODES                  : legal thermometer fine codes, index = value
//   SEG7                        : {g,f,e,d,c,b,a} patterns for digits 0..9
//   scan_state_t                : display multiplex state
package watch_pkg;

  localparam int unsigned FINE_STATES   = 5;
  localparam int unsigned COARSE_STATES = 12;

  localparam logic [11:0] COARSE_RESET = 12'b1000_0000_0000;
  localparam logic [3:0]  FINE_RESET   = 4'b0000;

  localparam logic [FINE_STATES-1:0][3:0] FINE_CODES =
    {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  localparam logic [9:0][6:0] SEG7 =
    {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  typedef enum logic {
    SCAN_ONES = 1'b0,
    SCAN_TENS = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD to seven-segment encoder.
//   bcd : 4-bit BCD digit (values above 9 give a blank pattern)
//   seg : active-high segments {g,f,e,d,c,b,a}
module seg7_encoder
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = SEG7[i];
    end
  end

endmodule

// File: rtl/watch_time_decoder.sv
// Decodes the watch's thermometer/one-hot seconds code into binary and BCD
// seconds, and multiplexes the two BCD digits onto a seven-segment display.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   sec_fine   : 4-bit thermometer seconds-fine code
//   sec_coarse : 12-bit one-hot seconds-coarse code
//   seconds    : decoded seconds 0..59
//   bcd_tens   : seconds / 10
//   bcd_ones   : seconds mod 10
//   tick       : one-cycle pulse when a new, different seconds value is accepted
//   time_valid : last stable code was legal
//   code_err   : sticky illegal-code flag, cleared only by rst
//   seg        : segments {g,f,e,d,c,b,a} of the selected digit, blank if invalid
//   digit_sel  : 01 = ones digit, 10 = tens digit
module watch_time_decoder
  import watch_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sec_fine,
  input  logic [11:0] sec_coarse,
  output logic [5:0]  seconds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic        tick,
  output logic        time_valid,
  output logic        code_err,
  output logic [6:0]  seg,
  output logic [1:0]  digit_sel
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [3:0]  s1_fine, s2_fine;
  logic [11:0] s1_coarse, s2_coarse;

  logic        stable;
  logic        fine_ok;
  logic        coarse_ok;
  logic [2:0]  fine_idx;
  logic [3:0]  coarse_idx;
  logic [5:0]  sec_calc;
  logic [3:0]  tens_calc;
  logic [3:0]  ones_calc;

  logic [15:0] presc;
  scan_state_t scan_state;
  logic [3:0]  digit_bcd;
  logic [6:0]  seg_raw;

  // Decode s1; it is only used when s1 matches s2, so s1 stands for both.
  always_comb begin
    stable     = (s1_fine == s2_fine) && (s1_coarse == s2_coarse);
    fine_ok    = 1'b0;
    fine_idx   = '0;
    for (int unsigned i = 0; i < FINE_STATES; i++) begin
      if (s1_fine == FINE_CODES[i]) begin
        fine_ok  = 1'b1;
        fine_idx = 3'(i);
      end
    end
    coarse_ok  = $onehot(s1_coarse);
    coarse_idx = '0;
    for (int unsigned p = 0; p < COARSE_STATES; p++) begin
      if (s1_coarse[p]) coarse_idx = 4'(COARSE_STATES - 1 - p);
    end
    // 5*c + f, at most 59
    sec_calc  = ({2'b00, coarse_idx} << 2) + {2'b00, coarse_idx} + {3'b000, fine_idx};
    tens_calc = 4'(sec_calc / 6'd10);
    ones_calc = 4'(sec_calc % 6'd10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_fine    <= FINE_RESET;
      s2_fine    <= FINE_RESET;
      s1_coarse  <= COARSE_RESET;
      s2_coarse  <= COARSE_RESET;
      seconds    <= '0;
      bcd_tens   <= '0;
      bcd_ones   <= '0;
      tick       <= 1'b0;
      time_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      s1_fine   <= sec_fine;
      s1_coarse <= sec_coarse;
      s2_fine   <= s1_fine;
      s2_coarse <= s1_coarse;
      tick      <= 1'b0;
      if (stable) begin
        if (fine_ok && coarse_ok) begin
          seconds    <= sec_calc;
          bcd_tens   <= tens_calc;
          bcd_ones   <= ones_calc;
          time_valid <= 1'b1;
          tick       <= (sec_calc != seconds);
        end else begin
          time_valid <= 1'b0;
          code_err   <= 1'b1;
        end
      end
    end
  end

  assign digit_bcd = (scan_state == SCAN_ONES) ? bcd_ones : bcd_tens;

  seg7_encoder u_seg7 (
    .bcd (digit_bcd),
    .seg (seg_raw)
  );

  // Outputs are registered from the current state, so digit_sel and seg
  // always move together one cycle after the state toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      scan_state <= SCAN_ONES;
      digit_sel  <= 2'b01;
      seg        <= '0;
    end else begin
      if (presc == DIV_LAST) begin
        presc      <= '0;
        scan_state <= (scan_state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
      end else begin
        presc <= presc + 16'd1;
      end
      digit_sel <= (scan_state == SCAN_ONES) ? 2'b01 : 2'b10;
      seg       <= time_valid ? seg_raw : '0;
    end
  end

endmodule

// File: tb/tb_watch_time_decoder.sv
module tb_watch_time_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sec_fine;
  logic [11:0] sec_coarse;
  logic [5:0]  seconds;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic        tick;
  logic        time_valid;
  logic        code_err;
  logic [6:0]  seg;
  logic [1:0]  digit_sel;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned ticks  = 0;
  int unsigned sb[$];

  logic [6:0] seg_tab [10];

  watch_time_decoder #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_fine   (sec_fine),
    .sec_coarse (sec_coarse),
    .seconds    (seconds),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .tick       (tick),
    .time_valid (time_valid),
    .code_err   (code_err),
    .seg        (seg),
    .digit_sel  (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the watch code for a seconds value (c = s/5 one-hot, f = s%5 thermometer).
  task automatic drive_sec(input int unsigned s);
    logic [3:0]  f;
    logic [11:0] c;
    f = 4'b1111;
    f = f << (4 - (s % 5));
    c = 12'b1;
    c = c << (11 - (s / 5));
    sec_fine   = f;
    sec_coarse = c;
  endtask

  // One clock; outputs sampled 1 time unit after the edge; ticks are scored here.
  task automatic step();
    int unsigned e;
    @(posedge clk);
    #1;
    if (tick === 1'b1) begin
      ticks++;
      if (sb.size() == 0) begin
        chk("spurious_tick", {31'b0, tick}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_seconds", {26'b0, seconds}, e);
        chk("sb_tens", {28'b0, bcd_tens}, e / 10);
        chk("sb_ones", {28'b0, bcd_ones}, e % 10);
        chk("sb_valid", {31'b0, time_valid}, 32'd1);
      end
    end
  endtask

  initial begin
    int unsigned prev;
    int unsigned t0;
    int unsigned len;
    int unsigned guard;
    logic [1:0]  cur;

    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reset with the watch reset code
    rst        = 1'b1;
    sec_fine   = 4'b0000;
    sec_coarse = 12'b1000_0000_0000;
    step(); step(); step();
    chk("rst_seconds", {26'b0, seconds}, 0);
    chk("rst_tick", {31'b0, tick}, 0);
    chk("rst_valid", {31'b0, time_valid}, 0);
    chk("rst_err", {31'b0, code_err}, 0);
    chk("rst_seg", {25'b0, seg}, 0);
    chk("rst_dsel", {30'b0, digit_sel}, 32'h1);
    rst = 1'b0;
    step(); step(); step();
    chk("post_rst_seconds", {26'b0, seconds}, 0);
    chk("post_rst_valid", {31'b0, time_valid}, 1);
    chk("post_rst_tick", {31'b0, tick}, 0);
    chk("post_rst_err", {31'b0, code_err}, 0);

    // Sweep all 60 codes, ending with the 59->0 wrap
    prev = 0;
    t0   = ticks;
    for (int unsigned k = 1; k <= 60; k++) begin
      drive_sec(k % 60);
      sb.push_back(k % 60);
      step(); step();
      chk("latency_hold", {26'b0, seconds}, prev);
      step();
      chk("latency_tick", {31'b0, tick}, 1);
      step();
      chk("tick_width", {31'b0, tick}, 0);
      step();
      prev = k % 60;
    end
    chk("sweep_ticks", ticks - t0, 60);
    chk("sweep_sb_empty", sb.size(), 0);

    // Scan multiplex at seconds = 37
    drive_sec(37);
    sb.push_back(37);
    step(); step(); step(); step(); step();
    cur   = digit_sel;
    guard = 0;
    while (digit_sel === cur && guard < 20) begin
      step();
      guard++;
    end
    chk("scan_toggles", {31'b0, (guard < 20)}, 1);
    for (int r = 0; r < 4; r++) begin
      cur = digit_sel;
      len = 0;
      while (digit_sel === cur && len < 10) begin
        if (cur == 2'b01) chk("seg_ones", {25'b0, seg}, {25'b0, seg_tab[7]});
        else              chk("seg_tens", {25'b0, seg}, {25'b0, seg_tab[3]});
        chk("dsel_legal", {31'b0, (digit_sel == 2'b01 || digit_sel == 2'b10)}, 1);
        step();
        len++;
      end
      chk("scan_period", len, 4);
    end

    // Unstable fine code: no update
    t0 = ticks;
    for (int i = 0; i < 12; i++) begin
      sec_fine = (i % 2 == 0) ? 4'b1000 : 4'b1100;
      step();
      chk("unstable_hold", {26'b0, seconds}, 37);
    end
    step(); step(); step();
    chk("unstable_ticks", ticks - t0, 0);
    chk("unstable_valid", {31'b0, time_valid}, 1);

    // Illegal coarse code
    sec_coarse = 12'b0;
    step(); step(); step();
    chk("illegal_valid", {31'b0, time_valid}, 0);
    chk("illegal_err", {31'b0, code_err}, 1);
    chk("illegal_hold", {26'b0, seconds}, 37);
    chk("illegal_bcd", {24'b0, bcd_tens, bcd_ones}, 32'h37);
    chk("illegal_tick", {31'b0, tick}, 0);
    step(); step();
    chk("illegal_blank", {25'b0, seg}, 0);
    drive_sec(12);
    sb.push_back(12);
    step(); step(); step(); step(); step();
    chk("recover_valid", {31'b0, time_valid}, 1);
    chk("recover_err", {31'b0, code_err}, 1);
    chk("recover_seconds", {26'b0, seconds}, 12);

    // Illegal fine code, then the same legal value again: no tick
    sec_fine = 4'b0100;
    step(); step(); step();
    chk("ill_fine_valid", {31'b0, time_valid}, 0);
    t0 = ticks;
    drive_sec(12);
    step(); step(); step(); step();
    chk("same_val_valid", {31'b0, time_valid}, 1);
    chk("same_val_noticks", ticks - t0, 0);

    // Reset on the update edge
    drive_sec(25);
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_seconds", {26'b0, seconds}, 0);
    chk("midrst_bcd", {24'b0, bcd_tens, bcd_ones}, 0);
    chk("midrst_tick", {31'b0, tick}, 0);
    chk("midrst_valid", {31'b0, time_valid}, 0);
    chk("midrst_err", {31'b0, code_err}, 0);
    chk("midrst_seg", {25'b0, seg}, 0);
    chk("midrst_dsel", {30'b0, digit_sel}, 32'h1);
    rst = 1'b0;
    sb.push_back(25);
    step(); step(); step(); step(); step();
    chk("after_rst_seconds", {26'b0, seconds}, 25);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
